// File: rtl/inst_rom_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the instruction ROM and inst_rom_arbiter.
// align_err exists only when ARB_ALIGN_CHK_EN is defined.
interface inst_rom_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic [31:0] if_rdata;
   logic        if_rvalid;
   logic        dbg_req;
   logic [31:0] dbg_addr;
   logic        dbg_gnt;
   logic [31:0] dbg_rdata;
   logic        dbg_rvalid;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
`ifdef ARB_ALIGN_CHK_EN
   logic        align_err;

   modport master (output if_req, if_addr, dbg_req, dbg_addr, rom_inst,
                   input  if_gnt, if_rdata, if_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
                          rom_ce, rom_addr, align_err);
   modport slave  (input  if_req, if_addr, dbg_req, dbg_addr, rom_inst,
                   output if_gnt, if_rdata, if_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
                          rom_ce, rom_addr, align_err);
`else
   modport master (output if_req, if_addr, dbg_req, dbg_addr, rom_inst,
                   input  if_gnt, if_rdata, if_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
                          rom_ce, rom_addr);
   modport slave  (input  if_req, if_addr, dbg_req, dbg_addr, rom_inst,
                   output if_gnt, if_rdata, if_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
                          rom_ce, rom_addr);
`endif
endinterface

// File: rtl/inst_rom_arbiter.sv
// Shares the single-port instruction ROM between IF fetch and debug reads; IF has priority,
// with a starvation guard for debug. Optional ARB_ALIGN_CHK_EN zeroes misaligned reads and flags align_err.
module inst_rom_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst,
   inst_rom_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RESP_IF, RESP_DBG} state_t;

   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
   logic             if_gnt, dbg_gnt;
   logic [31:0]      if_rdata, dbg_rdata;
   logic [31:0]      rdata_cap;

   assign dbg_gnt = bus.dbg_req & (~bus.if_req | (starve_cnt >= LIMIT));
   assign if_gnt  = bus.if_req & ~dbg_gnt;

   assign bus.if_gnt     = if_gnt;
   assign bus.dbg_gnt    = dbg_gnt;
   assign bus.rom_ce     = if_gnt | dbg_gnt;
   assign bus.rom_addr   = if_gnt ? bus.if_addr : (dbg_gnt ? bus.dbg_addr : 32'h0);
   assign bus.if_rdata   = if_rdata;
   assign bus.dbg_rdata  = dbg_rdata;
   assign bus.if_rvalid  = (state == RESP_IF);
   assign bus.dbg_rvalid = (state == RESP_DBG);

`ifdef ARB_ALIGN_CHK_EN
   logic misaligned;
   logic align_err;

   // The ROM is still accessed on a misaligned grant; only the returned word is suppressed.
   assign misaligned    = bus.rom_addr[1:0] != 2'b00;
   assign rdata_cap     = misaligned ? 32'h0 : bus.rom_inst;
   assign bus.align_err = align_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) align_err <= 1'b0;
      else      align_err <= (if_gnt | dbg_gnt) & misaligned;
   end
`else
   assign rdata_cap = bus.rom_inst;
`endif

   always_comb begin
      state_nxt      = IDLE;
      starve_cnt_nxt = '0;
      if (if_gnt)       state_nxt = RESP_IF;
      else if (dbg_gnt) state_nxt = RESP_DBG;
      if (bus.dbg_req && !dbg_gnt)
         starve_cnt_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
   end

   // State records which requester owns the read returning next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         if_rdata   <= 32'h0;
         dbg_rdata  <= 32'h0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
         if (if_gnt)  if_rdata  <= rdata_cap;
         if (dbg_gnt) dbg_rdata <= rdata_cap;
      end
   end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the grant rules and response timing.
module tb_inst_rom_arbiter;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   inst_rom_arbiter_if bus();

   inst_rom_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   assign bus.rom_inst = mem[bus.rom_addr[9:2]];

   // Reference model state: consecutive denied debug cycles and the expected registered outputs.
   int          m_cnt;
   logic        e_if_v, e_dbg_v, e_al;
   logic [31:0] e_if_d, e_dbg_d;

   function automatic logic [31:0] word_of(input logic [31:0] a);
`ifdef ARB_ALIGN_CHK_EN
      if (a[1:0] != 2'b00) return 32'h0;
`endif
      return mem[a[9:2]];
   endfunction

   function automatic logic m_dbg_gnt();
      return bus.dbg_req && (!bus.if_req || m_cnt >= STARVE_LIMIT);
   endfunction

   function automatic logic m_if_gnt();
      return bus.if_req && !m_dbg_gnt();
   endfunction

   task automatic model_reset();
      m_cnt = 0; e_if_v = 0; e_dbg_v = 0; e_al = 0; e_if_d = 0; e_dbg_d = 0;
   endtask

   // Advance one clock: model what the edge captures, then return 1 time unit after the edge.
   task automatic tick();
      logic gd, gi, al_i, al_d;
      logic [31:0] wi, wd;
      gd = m_dbg_gnt(); gi = m_if_gnt();
      wi = word_of(bus.if_addr); wd = word_of(bus.dbg_addr);
      al_i = bus.if_addr[1:0] != 2'b00; al_d = bus.dbg_addr[1:0] != 2'b00;
      if (bus.dbg_req && !gd) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else                    m_cnt = 0;
      @(posedge clk);
      e_if_v = gi; e_dbg_v = gd;
      e_al = (gi && al_i) || (gd && al_d);
      if (gi) e_if_d = wi;
      if (gd) e_dbg_d = wd;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.if_req = 0; bus.if_addr = 0; bus.dbg_req = 0; bus.dbg_addr = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_reset();
      #1 rst = 1'b0;
      #2;
      vectors++;
      if (bus.if_rvalid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL reset_rvalid: got if=%b dbg=%b, want 0 0", bus.if_rvalid, bus.dbg_rvalid);
      end
      vectors++;
      if (bus.if_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
         miscompares++; $display("FAIL reset_rdata: got if=%h dbg=%h, want 0 0", bus.if_rdata, bus.dbg_rdata);
      end
      vectors++;
      if (bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h0) begin
         miscompares++; $display("FAIL reset_rom: got ce=%b addr=%h, want 0 0", bus.rom_ce, bus.rom_addr);
      end
`ifdef ARB_ALIGN_CHK_EN
      vectors++;
      if (bus.align_err !== 1'b0) begin
         miscompares++; $display("FAIL reset_align_err: got %b, want 0", bus.align_err);
      end
`endif
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      tick();
   endtask

   task automatic test_if_back_to_back();
      for (int i = 0; i < 4; i++) begin
         bus.if_req = (i < 3);
         bus.if_addr = (i < 3) ? 32'(i * 4) : 32'h0;
         #4;
         if (i < 3) begin
            vectors++;
            if (bus.if_gnt !== 1'b1 || bus.rom_addr !== 32'(i * 4)) begin
               miscompares++; $display("FAIL if_b2b_gnt[%0d]: got gnt=%b addr=%h, want 1 %h", i, bus.if_gnt, bus.rom_addr, i * 4);
            end
         end
         if (i > 0) begin
            vectors++;
            if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== mem[i-1]) begin
               miscompares++; $display("FAIL if_b2b_rdata[%0d]: got v=%b d=%h, want 1 %h", i, bus.if_rvalid, bus.if_rdata, mem[i-1]);
            end
         end
         tick();
      end
      #4;
      vectors++;
      if (bus.if_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL if_b2b_end: got rvalid=%b, want 0", bus.if_rvalid);
      end
      tick();
   endtask

   task automatic test_dbg_alone();
      bus.dbg_req = 1; bus.dbg_addr = 32'h10;
      #4;
      vectors++;
      if (bus.dbg_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h10) begin
         miscompares++; $display("FAIL dbg_alone_gnt: got dgnt=%b igns=%b ce=%b addr=%h, want 1 0 1 00000010",
                                 bus.dbg_gnt, bus.if_gnt, bus.rom_ce, bus.rom_addr);
      end
      tick();
      bus.dbg_req = 0;
      #4;
      vectors++;
      if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== mem[4] || bus.if_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL dbg_alone_rdata: got v=%b d=%h iv=%b, want 1 %h 0", bus.dbg_rvalid, bus.dbg_rdata, bus.if_rvalid, mem[4]);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      bus.if_req = 1; bus.if_addr = 32'h20;
      #4;
      vectors++;
      if (bus.if_gnt !== 1'b1) begin
         miscompares++; $display("FAIL mid_reset_gnt: got %b, want 1", bus.if_gnt);
      end
      #1 rst = 1'b0;
      bus.if_req = 0;
      #1;
      vectors++;
      if (bus.if_rvalid !== 0 || bus.dbg_rvalid !== 0 || bus.if_rdata !== 0 || bus.dbg_rdata !== 0 ||
          bus.rom_ce !== 0 || bus.rom_addr !== 0) begin
         miscompares++; $display("FAIL mid_reset_out: got iv=%b dv=%b id=%h dd=%h ce=%b addr=%h, want all 0",
                                 bus.if_rvalid, bus.dbg_rvalid, bus.if_rdata, bus.dbg_rdata, bus.rom_ce, bus.rom_addr);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin
         miscompares++; $display("FAIL mid_reset_drop: got v=%b d=%h, want 0 0", bus.if_rvalid, bus.if_rdata);
      end
      #3 rst = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_starvation();
      bus.if_req = 1; bus.if_addr = 32'h80;
      bus.dbg_req = 1; bus.dbg_addr = 32'h40;
      for (int c = 0; c < 5; c++) begin
         #4;
         vectors++;
         if (bus.dbg_gnt !== (c == 4) || bus.if_gnt !== (c != 4)) begin
            miscompares++; $display("FAIL starve_gnt[%0d]: got dgnt=%b ignt=%b, want %b %b", c, bus.dbg_gnt, bus.if_gnt, c == 4, c != 4);
         end
         if (c == 4) begin
            vectors++;
            if (bus.rom_addr !== 32'h40) begin
               miscompares++; $display("FAIL starve_addr: got %h, want 00000040", bus.rom_addr);
            end
         end
         tick();
      end
      bus.dbg_req = 0;
      #4;
      vectors++;
      if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== mem[16] || bus.if_gnt !== 1'b1) begin
         miscompares++; $display("FAIL starve_resp: got v=%b d=%h ignt=%b, want 1 %h 1", bus.dbg_rvalid, bus.dbg_rdata, bus.if_gnt, mem[16]);
      end
      tick();
      bus.dbg_req = 1; bus.dbg_addr = 32'h44;
      #4;
      vectors++;
      if (bus.dbg_gnt !== 1'b0) begin
         miscompares++; $display("FAIL starve_cleared: got dgnt=%b, want 0", bus.dbg_gnt);
      end
      tick();
      bus.if_req = 0;
      #4;
      vectors++;
      if (bus.dbg_gnt !== 1'b1) begin
         miscompares++; $display("FAIL starve_release: got dgnt=%b, want 1", bus.dbg_gnt);
      end
      tick();
      bus.dbg_req = 0;
      tick();
   endtask

   task automatic test_idle();
      logic [31:0] hold_i, hold_d;
      bus.if_req = 0; bus.dbg_req = 0;
      hold_i = bus.if_rdata; hold_d = bus.dbg_rdata;
      for (int c = 0; c < 5; c++) begin
         #4;
         vectors++;
         if (bus.rom_ce !== 0 || bus.rom_addr !== 0 || bus.if_rvalid !== 0 || bus.dbg_rvalid !== 0 ||
             bus.if_rdata !== hold_i || bus.dbg_rdata !== hold_d) begin
            miscompares++; $display("FAIL idle[%0d]: got ce=%b addr=%h iv=%b dv=%b id=%h dd=%h, want 0 0 0 0 %h %h",
                                    c, bus.rom_ce, bus.rom_addr, bus.if_rvalid, bus.dbg_rvalid, bus.if_rdata, bus.dbg_rdata, hold_i, hold_d);
         end
         tick();
      end
   endtask

   task automatic test_align();
      logic [31:0] want;
`ifdef ARB_ALIGN_CHK_EN
      want = 32'h0;
`else
      want = mem[1];
`endif
      bus.if_req = 1; bus.if_addr = 32'h6;
      #4;
      tick();
      bus.if_req = 0;
      #4;
      vectors++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== want) begin
         miscompares++; $display("FAIL align_rdata: got v=%b d=%h, want 1 %h", bus.if_rvalid, bus.if_rdata, want);
      end
`ifdef ARB_ALIGN_CHK_EN
      vectors++;
      if (bus.align_err !== 1'b1) begin
         miscompares++; $display("FAIL align_err_pulse: got %b, want 1", bus.align_err);
      end
`endif
      tick();
      #4;
`ifdef ARB_ALIGN_CHK_EN
      vectors++;
      if (bus.align_err !== 1'b0) begin
         miscompares++; $display("FAIL align_err_clear: got %b, want 0", bus.align_err);
      end
`endif
      vectors++;
      if (bus.if_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL align_rvalid_clear: got %b, want 0", bus.if_rvalid);
      end
      tick();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = ($urandom_range(0, 255) << 2) | ($urandom & 32'hFFF0_0000);
      if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
      return a;
   endfunction

   task automatic test_random();
      logic [31:0] want_addr;
      logic eg_i, eg_d;
      for (int c = 0; c < 400; c++) begin
         bus.if_req = ($urandom_range(0, 3) != 0);
         bus.if_addr = rand_addr();
         if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
            bus.dbg_req = 1; bus.dbg_addr = rand_addr();
         end
         #4;
         eg_i = m_if_gnt(); eg_d = m_dbg_gnt();
         want_addr = eg_i ? bus.if_addr : (eg_d ? bus.dbg_addr : 32'h0);
         vectors++;
         if (bus.if_gnt !== eg_i || bus.dbg_gnt !== eg_d) begin
            miscompares++; $display("FAIL rand_gnt[%0d]: got ignt=%b dgnt=%b, want %b %b", c, bus.if_gnt, bus.dbg_gnt, eg_i, eg_d);
         end
         vectors++;
         if (bus.rom_ce !== (eg_i | eg_d) || bus.rom_addr !== want_addr) begin
            miscompares++; $display("FAIL rand_rom[%0d]: got ce=%b addr=%h, want %b %h", c, bus.rom_ce, bus.rom_addr, eg_i | eg_d, want_addr);
         end
         vectors++;
         if (bus.if_rvalid !== e_if_v || bus.if_rdata !== e_if_d) begin
            miscompares++; $display("FAIL rand_if_resp[%0d]: got v=%b d=%h, want %b %h", c, bus.if_rvalid, bus.if_rdata, e_if_v, e_if_d);
         end
         vectors++;
         if (bus.dbg_rvalid !== e_dbg_v || bus.dbg_rdata !== e_dbg_d) begin
            miscompares++; $display("FAIL rand_dbg_resp[%0d]: got v=%b d=%h, want %b %h", c, bus.dbg_rvalid, bus.dbg_rdata, e_dbg_v, e_dbg_d);
         end
`ifdef ARB_ALIGN_CHK_EN
         vectors++;
         if (bus.align_err !== e_al) begin
            miscompares++; $display("FAIL rand_align_err[%0d]: got %b, want %b", c, bus.align_err, e_al);
         end
`endif
         tick();
         if (eg_d) bus.dbg_req = 0;
      end
      bus.if_req = 0; bus.dbg_req = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_if_back_to_back();
      test_dbg_alone();
      test_reset_mid_read();
      test_starvation();
      test_idle();
      test_align();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
